// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core: fetch FSM states,
// the canonical NOP encoding, major opcodes and a counter-width helper.
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  // Width of a counter that must reach max_wait; never narrower than 1 bit.
  function automatic int unsigned ctr_width(input int unsigned max_wait);
    return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter with a terminal-count flag, used to time out fetches.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          load load_val this cycle (has priority over en)
//   load_val      value to load
//   en            increment by one
//   term_c        combinational: count equals TERM (held low when TERM_EN=0)
module fetch_timeout_ctr
  import riscv_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned TERM    = 14,
  parameter bit          TERM_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_c = TERM_EN && (cnt_q == W'(TERM));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle RISC-V core. Holds the PC, issues word reads
// to instruction memory over a req/ready handshake and latches the returned
// word into the instruction register, keeping the PC of that instruction.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   fetch_start          start a fetch at the current pc (ignored while busy)
//   pc_write, pc_next    load pc_next into pc (any state)
//   mem_req, mem_addr    memory read request / address (addr = pc when idle)
//   mem_rdata, mem_ready returned instruction word and its valid strobe
//   instr, imm_field, op instruction register and its extender/controller slices
//   pc, old_pc           current PC and PC of the instruction in IR
//   fetch_done           one-cycle pulse aligned with an IR update
//   fetch_err            one-cycle pulse on timeout or misaligned pc
//   busy                 high while a fetch is outstanding
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] instr,
  output logic [24:0]     imm_field,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic            busy
);

  localparam int unsigned CW   = ctr_width(MAX_WAIT);
  // Terminal count is one below MAX_WAIT: the flag is seen in the cycle whose
  // increment would reach MAX_WAIT.
  localparam int unsigned TERM = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic            busy_q, busy_d;
  logic            fetch_done_q, fetch_done_d;
  logic            fetch_err_q, fetch_err_d;
  logic            ctr_load, ctr_en, ctr_term;

  fetch_timeout_ctr #(
    .W       (CW),
    .TERM    (TERM),
    .TERM_EN (MAX_WAIT != 0)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (reset),
    .load     (ctr_load),
    .load_val (CW'(0)),
    .en       (ctr_en),
    .term_c   (ctr_term)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_write ? pc_next : pc_q;
    addr_d       = addr_q;
    old_pc_d     = old_pc_q;
    instr_d      = instr_q;
    fetch_done_d = 1'b0;
    fetch_err_d  = 1'b0;
    ctr_load     = 1'b0;
    ctr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_start) begin
          if (pc_q[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
          end else begin
            state_d  = REQ;
            addr_d   = pc_q;
            ctr_load = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d      = IDLE;
          instr_d      = mem_rdata;
          old_pc_d     = addr_q;
          fetch_done_d = 1'b1;
        end else if (ctr_term) begin
          state_d     = IDLE;
          fetch_err_d = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory-side outputs follow the next state so they are registered and
    // the address cannot move while a request is held.
    mem_req_d  = (state_d == REQ);
    busy_d     = (state_d == REQ);
    mem_addr_d = (state_d == REQ) ? addr_d : pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= XLEN'(NOP_INSTR);
      mem_addr_q   <= RESET_PC;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      old_pc_q     <= old_pc_d;
      instr_q      <= instr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
      fetch_done_q <= fetch_done_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign pc         = pc_q;
  assign old_pc     = old_pc_q;
  assign instr      = instr_q;
  assign fetch_done = fetch_done_q;
  assign fetch_err  = fetch_err_q;
  assign imm_field  = instr_q[31:7];
  assign op         = instr_q[6:0];

endmodule
